// File: rtl/multicycle_sequencer_if.sv
// Memory handshake bundle between the multi-cycle sequencer and the
// instruction/data memories (request/ack per memory plus data write qualifier).
interface multicycle_sequencer_if;
  logic imem_req;
  logic imem_ack;
  logic dmem_req;
  logic dmem_we;
  logic dmem_ack;

  modport master (
    output imem_req,
    output dmem_req,
    output dmem_we,
    input  imem_ack,
    input  dmem_ack
  );

  modport slave (
    input  imem_req,
    input  dmem_req,
    input  dmem_we,
    output imem_ack,
    output dmem_ack
  );
endinterface

// File: rtl/multicycle_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB controller with variable-latency memory handshakes.
// Optional build macro SEQ_STEP_EN: every retire parks in HALT until a step pulse.
//
// state  | meaning
// IDLE   | waiting for start, pc_load follows start
// FETCH  | imem request outstanding, ir_we on ack
// DECODE | decoder bits settle, illegal combos fault
// EXEC   | ALU result captured, route to MEM/WB/retire
// MEM    | dmem request outstanding, mdr_we or retire on ack
// WB     | register file write and retire
// FAULT  | sticky error, left only through reset
// HALT   | single-step park after retire
module multicycle_sequencer #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 32
) (
  input  logic                     CLK,
  input  logic                     resetl,
  input  logic                     start,
  input  logic                     dec_valid,
  input  logic                     dec_regwrite,
  input  logic                     dec_memread,
  input  logic                     dec_memwrite,
  input  logic                     dec_branch,
  input  logic                     step,
  multicycle_sequencer_if.master   mem,
  output logic                     pc_load,
  output logic                     pc_we,
  output logic                     ir_we,
  output logic                     alu_we,
  output logic                     mdr_we,
  output logic                     rf_we,
  output logic                     busy,
  output logic                     fault,
  output logic                     halted,
  output logic [2:0]               state,
  output logic [CNT_W-1:0]         instr_count
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_FAULT  = 3'd6,
    ST_HALT   = 3'd7
  } state_t;

  localparam int TW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [TW-1:0] TOUT_LAST = TW'(MEM_TIMEOUT - 1);

`ifdef SEQ_STEP_EN
  localparam state_t RETIRE_DST = ST_HALT;
`else
  localparam state_t RETIRE_DST = ST_FETCH;
`endif

  state_t            state_q;
  state_t            state_d;
  logic [TW-1:0]     tout_q;
  logic [CNT_W-1:0]  count_q;
  logic              tout_hit;
  logic              mem_op;

  assign tout_hit = (tout_q == TOUT_LAST);
  assign mem_op   = dec_memread | dec_memwrite;

  // tout only runs while a request stays unanswered in the same state
  always_ff @(posedge CLK) begin
    if (!resetl) begin
      state_q <= ST_IDLE;
      tout_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      if (((state_q == ST_FETCH) || (state_q == ST_MEM)) && (state_d == state_q)) begin
        tout_q <= tout_q + 1'b1;
      end else begin
        tout_q <= '0;
      end
      if (pc_we) begin
        count_q <= count_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (mem.imem_ack)  state_d = ST_DECODE;
        else if (tout_hit) state_d = ST_FAULT;
      end
      ST_DECODE: begin
        if (!dec_valid || (dec_memread && dec_memwrite)) state_d = ST_FAULT;
        else                                             state_d = ST_EXEC;
      end
      ST_EXEC: begin
        if (mem_op)                        state_d = ST_MEM;
        else if (!dec_branch && dec_regwrite) state_d = ST_WB;
        else                               state_d = RETIRE_DST;
      end
      ST_MEM: begin
        if (mem.dmem_ack) state_d = dec_memwrite ? RETIRE_DST : ST_WB;
        else if (tout_hit) state_d = ST_FAULT;
      end
      ST_WB:    state_d = RETIRE_DST;
      ST_FAULT: state_d = ST_FAULT;
      ST_HALT: begin
        if (step) state_d = ST_FETCH;
      end
      default:  state_d = ST_FAULT;
    endcase
  end

  // every strobe is held low while reset is asserted so an aborted access never retires
  always_comb begin
    pc_load      = 1'b0;
    pc_we        = 1'b0;
    ir_we        = 1'b0;
    alu_we       = 1'b0;
    mdr_we       = 1'b0;
    rf_we        = 1'b0;
    mem.imem_req = 1'b0;
    mem.dmem_req = 1'b0;
    mem.dmem_we  = 1'b0;
    busy         = 1'b0;
    fault        = 1'b0;
    halted       = 1'b0;
    if (resetl) begin
      busy   = (state_q != ST_IDLE) && (state_q != ST_FAULT);
      fault  = (state_q == ST_FAULT);
      halted = (state_q == ST_HALT);
      case (state_q)
        ST_IDLE: pc_load = start;
        ST_FETCH: begin
          mem.imem_req = 1'b1;
          ir_we        = mem.imem_ack;
        end
        ST_EXEC: begin
          alu_we = 1'b1;
          pc_we  = !mem_op && (dec_branch || !dec_regwrite);
        end
        ST_MEM: begin
          mem.dmem_req = 1'b1;
          mem.dmem_we  = dec_memwrite;
          if (mem.dmem_ack) begin
            pc_we  = dec_memwrite;
            mdr_we = !dec_memwrite;
          end
        end
        ST_WB: begin
          rf_we = dec_regwrite;
          pc_we = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign state       = state_q;
  assign instr_count = count_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Scoreboard bench for multicycle_sequencer: random instructions and memory
// latencies, expected per-instruction strobe profile computed from the cycle rules.
module tb_multicycle_sequencer;
  localparam int T  = 15;
  localparam int CW = 4;

  logic CLK = 1'b0;
  logic resetl = 1'b0;
  logic start = 1'b0;
  logic dec_valid = 1'b0, dec_regwrite = 1'b0, dec_memread = 1'b0;
  logic dec_memwrite = 1'b0, dec_branch = 1'b0, step = 1'b0;
  logic pc_load, pc_we, ir_we, alu_we, mdr_we, rf_we, busy, fault, halted;
  logic [2:0]    state;
  logic [CW-1:0] instr_count;

  multicycle_sequencer_if mif();

  multicycle_sequencer #(.MEM_TIMEOUT(T), .CNT_W(CW)) dut (
    .CLK(CLK), .resetl(resetl), .start(start),
    .dec_valid(dec_valid), .dec_regwrite(dec_regwrite), .dec_memread(dec_memread),
    .dec_memwrite(dec_memwrite), .dec_branch(dec_branch), .step(step),
    .mem(mif),
    .pc_load(pc_load), .pc_we(pc_we), .ir_we(ir_we), .alu_we(alu_we), .mdr_we(mdr_we),
    .rf_we(rf_we), .busy(busy), .fault(fault), .halted(halted),
    .state(state), .instr_count(instr_count)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    bit flt;
    int cycles, imem, dmem, dmwe, mdr, rf, alu, ir, cnt;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  int   model_cnt = 0;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  // expected profile of one instruction from its decode bits and memory waits
  function automatic exp_t model(input bit v, rg, rd, wr, br, input int wi, wd);
    exp_t e;
    e = '{flt: 1'b0, cycles: 0, imem: 0, dmem: 0, dmwe: 0, mdr: 0, rf: 0, alu: 0, ir: 0, cnt: model_cnt};
    if (wi >= T) begin
      e.flt = 1'b1; e.cycles = T; e.imem = T;
      return e;
    end
    e.imem = wi + 1; e.ir = 1; e.cycles = wi + 2;
    if (!v || (rd && wr)) begin
      e.flt = 1'b1;
      return e;
    end
    e.alu = 1; e.cycles++;
    if (rd || wr) begin
      if (wd >= T) begin
        e.flt = 1'b1; e.cycles += T; e.dmem = T; e.dmwe = wr ? T : 0;
        return e;
      end
      e.dmem = wd + 1; e.dmwe = wr ? wd + 1 : 0; e.cycles += wd + 1;
      if (!wr) begin e.mdr = 1; e.rf = int'(rg); e.cycles++; end
    end else if (!br && rg) begin
      e.rf = 1; e.cycles++;
    end
    return e;
  endfunction

  // monitor: accumulate strobes per instruction, compare on retire or fault entry
  int a_cyc, a_im, a_dm, a_dw, a_mdr, a_rf, a_alu, a_ir;
  bit prev_fault;
  initial begin
    exp_t e;
    a_cyc = 0; a_im = 0; a_dm = 0; a_dw = 0; a_mdr = 0; a_rf = 0; a_alu = 0; a_ir = 0;
    prev_fault = 1'b0;
    forever begin
      @(negedge CLK);
      if (!resetl) begin
        a_cyc = 0; a_im = 0; a_dm = 0; a_dw = 0; a_mdr = 0; a_rf = 0; a_alu = 0; a_ir = 0;
        prev_fault = 1'b0;
      end else begin
        if (busy && !halted) begin
          a_cyc++;
          a_im  += int'(mif.imem_req);
          a_dm  += int'(mif.dmem_req);
          a_dw  += int'(mif.dmem_we);
          a_mdr += int'(mdr_we);
          a_rf  += int'(rf_we);
          a_alu += int'(alu_we);
          a_ir  += int'(ir_we);
        end
        if (busy && start) chk("pc_load_while_busy", int'(pc_load), 0);
        if (fault)
          chk("fault_quiet", int'(pc_load | pc_we | ir_we | alu_we | mdr_we | rf_we |
                                  mif.imem_req | mif.dmem_req | mif.dmem_we | busy | halted), 0);
        if (pc_we || (fault && !prev_fault)) begin
          if (sbq.size() == 0) begin
            checks++; errors++;
            $display("FAIL scoreboard_empty: got event pc_we=%0d fault=%0d, expected none", pc_we, fault);
          end else begin
            e = sbq.pop_front();
            chk("outcome_fault", int'(fault), int'(e.flt));
            chk("cycles", a_cyc, e.cycles);
            chk("imem_req_cycles", a_im, e.imem);
            chk("dmem_req_cycles", a_dm, e.dmem);
            chk("dmem_we_cycles", a_dw, e.dmwe);
            chk("mdr_we", a_mdr, e.mdr);
            chk("rf_we", a_rf, e.rf);
            chk("alu_we", a_alu, e.alu);
            chk("ir_we", a_ir, e.ir);
            if (pc_we) chk("instr_count", int'(instr_count), e.cnt);
          end
          a_cyc = 0; a_im = 0; a_dm = 0; a_dw = 0; a_mdr = 0; a_rf = 0; a_alu = 0; a_ir = 0;
        end
        prev_fault = fault;
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic serve_imem(input int w);
    for (int n = 0; n < T + 4; n++) begin
      if (!mif.imem_req) return;
      mif.dmem_ack = 1'($urandom_range(0, 1));
      start        = 1'($urandom_range(0, 1));
      if (n == w) mif.imem_ack = 1'b1;
      tick();
      mif.imem_ack = 1'b0; mif.dmem_ack = 1'b0; start = 1'b0;
      if (n == w) return;
    end
  endtask

  task automatic serve_dmem(input int w);
    for (int n = 0; n < T + 4; n++) begin
      if (!mif.dmem_req) return;
      mif.imem_ack = 1'($urandom_range(0, 1));
      start        = 1'($urandom_range(0, 1));
      if (n == w) mif.dmem_ack = 1'b1;
      tick();
      mif.imem_ack = 1'b0; mif.dmem_ack = 1'b0; start = 1'b0;
      if (n == w) return;
    end
  endtask

  task automatic wait_for(input bit want_dmem);
    for (int n = 0; n < 24; n++) begin
      if (fault || mif.imem_req || (want_dmem && mif.dmem_req)) return;
`ifdef SEQ_STEP_EN
      if (halted) begin
        step = 1'b1; tick(); step = 1'b0;
        continue;
      end
`endif
      tick();
    end
    checks++; errors++;
    $display("FAIL wait_budget: got state=%0d, expected a request or fault within 24 cycles", state);
  endtask

  task automatic do_reset();
    resetl = 1'b0; start = 1'b1;
    mif.imem_ack = 1'($urandom_range(0, 1));
    mif.dmem_ack = 1'($urandom_range(0, 1));
    tick(); tick();
    chk("reset_state", int'(state), 0);
    chk("reset_outputs", int'(pc_load | pc_we | ir_we | alu_we | mdr_we | rf_we | mif.imem_req |
                              mif.dmem_req | mif.dmem_we | busy | fault | halted), 0);
    chk("reset_count", int'(instr_count), 0);
    resetl = 1'b1; start = 1'b0; mif.imem_ack = 1'b0; mif.dmem_ack = 1'b0;
    model_cnt = 0;
    tick();
    chk("idle_after_reset", int'(state), 0);
    chk("sb_drained", sbq.size(), 0);
    sbq.delete();
  endtask

  task automatic do_start();
    start = 1'b1;
    #1;
    chk("pc_load_on_start", int'(pc_load), 1);
    tick();
    start = 1'b0;
    chk("fetch_after_start", int'(state), 1);
  endtask

  task automatic handle_fault();
    chk("fault_state", int'(state), 6);
    for (int i = 0; i < 3; i++) begin
      start = 1'b1; mif.imem_ack = 1'b1; mif.dmem_ack = 1'b1;
      tick();
      chk("fault_sticky", int'(fault), 1);
      chk("fault_state_held", int'(state), 6);
    end
    start = 1'b0; mif.imem_ack = 1'b0; mif.dmem_ack = 1'b0;
    do_reset();
    do_start();
  endtask

  task automatic do_instr(input bit v, rg, rd, wr, br, input int wi, wd);
    exp_t e;
    dec_valid = v; dec_regwrite = rg; dec_memread = rd; dec_memwrite = wr; dec_branch = br;
    e = model(v, rg, rd, wr, br, wi, wd);
    sbq.push_back(e);
    if (!e.flt) model_cnt = (model_cnt + 1) % (1 << CW);
    serve_imem(wi);
    if (rd || wr) begin
      wait_for(1'b1);
      if (mif.dmem_req) serve_dmem(wd);
    end
    wait_for(1'b0);
    if (e.flt) begin
      tick();
      handle_fault();
    end
  endtask

  function automatic int rand_wait();
    int r;
    r = int'($urandom_range(0, 99));
    if (r < 85) return int'($urandom_range(0, 3));
    if (r < 92) return T - 1;
    return T;
  endfunction

  initial begin
    mif.imem_ack = 1'b0; mif.dmem_ack = 1'b0;
    do_reset();
    do_start();
    do_instr(1, 1, 0, 0, 0, 0, 0);      // ADD
    do_instr(1, 1, 1, 0, 0, 0, 3);      // LDUR, three waits
    do_instr(1, 0, 0, 1, 0, 1, 0);      // STUR
    do_instr(1, 1, 0, 0, 1, 0, 0);      // CBZ/B with regwrite ignored
    do_instr(1, 0, 0, 0, 0, 2, 0);      // no-writeback ALU op
    for (int i = 0; i < 20; i++) do_instr(1, 1, 0, 0, 0, 0, 0);
    do_instr(1, 1, 0, 0, 0, T - 1, 0);  // ack on last allowed fetch cycle
    do_instr(1, 1, 1, 0, 0, 0, T - 1);
    do_instr(1, 1, 0, 0, 0, T, 0);      // fetch timeout
    do_instr(1, 1, 1, 0, 0, 0, T);      // data timeout
    do_instr(0, 1, 0, 0, 0, 0, 0);      // invalid opcode
    do_instr(1, 0, 1, 1, 0, 0, 0);      // read and write together
    for (int i = 0; i < 250; i++) begin
      bit v, rg, rd, wr, br;
      int k;
      v  = ($urandom_range(0, 15) != 0);
      rg = 1'($urandom_range(0, 1));
      br = ($urandom_range(0, 3) == 0);
      k  = int'($urandom_range(0, 9));
      rd = (k <= 2) || (k == 9);
      wr = (k == 3) || (k == 4) || (k == 9);
      do_instr(v, rg, rd, wr, br, rand_wait(), rand_wait());
    end
    repeat (3) tick();
    chk("sb_empty_at_end", sbq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end
endmodule
